alu_req_arbiter: RTL and testbench

- Shares one registered ALU among NUM_REQ requesters (e.g. system controller, test/loopback path).
- Arbitrates round-robin, latches the winner's operands and opcode, and drives the ALU enable for exactly one cycle.
- Captures the registered ALU result and returns it to the owning requester as a one-cycle response pulse.
- Flags opcodes for which the ALU produced no valid output.

---
 rtl/alu_req_arbiter_if.sv | 31 +++
 rtl/alu_req_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_arbiter_if.sv
// Requester/ALU bundle for alu_req_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/ALU side.
interface alu_req_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 3
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ*4-1:0]          req_fun;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [2*DATA_WIDTH-1:0]       rsp_data;
    logic                          rsp_err;
    logic [DATA_WIDTH-1:0]         alu_a;
    logic [DATA_WIDTH-1:0]         alu_b;
    logic [3:0]                    alu_fun;
    logic                          alu_en;
    logic [2*DATA_WIDTH-1:0]       alu_out;
    logic                          alu_out_valid;

    modport slave (
        input  req_valid, req_a, req_b, req_fun, alu_out, alu_out_valid,
        output req_ready, rsp_valid, rsp_data, rsp_err, alu_a, alu_b, alu_fun, alu_en
    );

    modport master (
        output req_valid, req_a, req_b, req_fun, alu_out, alu_out_valid,
        input  req_ready, rsp_valid, rsp_data, rsp_err, alu_a, alu_b, alu_fun, alu_en
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered ALU among NUM_REQ requesters.
// Optional op/error counters are built when ALU_ARB_STATS_EN is defined.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | grant offered to first valid requester from r_ptr; accept latches operands
//   ST_ISSUE | alu_en pulsed for one cycle with latched operands
//   ST_WAIT  | registered ALU result captured into response at the closing edge
module alu_req_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 3
) (
    input  logic             CLK,
    input  logic             RST,
    alu_req_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]      op_count,
    output logic [7:0]       err_count
`endif
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_owner;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [3:0]              r_fun;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [2*DATA_WIDTH-1:0] r_rsp_data;
    logic                    r_rsp_err;

    logic [NUM_REQ-1:0]      w_grant;
    logic [PTR_W-1:0]        w_gidx;
    logic [PTR_W-1:0]        w_cand;
    logic                    w_found;
    int                      w_idx;
    logic [NUM_REQ-1:0]      w_req_ready;
    logic                    w_alu_en;
    logic                    w_accept;
    logic [PTR_W-1:0]        w_ptr_nxt;
    logic [NUM_REQ-1:0]      w_owner_oh;

    // Rotating priority search: first asserted request at or above r_ptr, wrapping.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_cand  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_cand = PTR_W'(w_idx);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found         = 1'b1;
                w_gidx          = w_cand;
                w_grant[w_cand] = 1'b1;
            end
        end
    end

    always_comb begin
        w_ptr_nxt = (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + PTR_W'(1);
    end

    always_comb begin
        w_owner_oh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_owner_oh[k] = (int'(r_owner) == k);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // req_ready is gated by RST so nothing is offered while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_alu_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (RST) begin
                    w_req_ready = w_grant;
                end
                if (|(bus.req_valid & w_req_ready)) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_alu_en    = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept = |(bus.req_valid & w_req_ready);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_fun       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= bus.req_a[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
                r_b     <= bus.req_b[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
                r_fun   <= bus.req_fun[int'(w_gidx)*4 +: 4];
                r_owner <= w_gidx;
                r_ptr   <= w_ptr_nxt;
            end
            if (r_state == ST_WAIT) begin
                r_rsp_data  <= bus.alu_out_valid ? bus.alu_out : '0;
                r_rsp_err   <= ~bus.alu_out_valid;
                r_rsp_valid <= w_owner_oh;
            end else begin
                r_rsp_valid <= '0;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_op_count;
    logic [7:0]  r_err_count;

    // Counters step on the same edge that launches the response pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_op_count  <= '0;
            r_err_count <= '0;
        end else if (r_state == ST_WAIT) begin
            r_op_count <= r_op_count + 16'd1;
            if (!bus.alu_out_valid && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign op_count  = r_op_count;
    assign err_count = r_err_count;
`endif

    assign bus.req_ready = w_req_ready;
    assign bus.alu_en    = w_alu_en;
    assign bus.alu_a     = r_a;
    assign bus.alu_b     = r_b;
    assign bus.alu_fun   = r_fun;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter with a small registered ALU model.
module tb_alu_req_arbiter;
    logic CLK;
    logic RST;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    alu_req_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(3)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [15:0] op_count;
    logic [7:0]  err_count;
    alu_req_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3)) dut (
        .CLK(CLK), .RST(RST), .bus(bus), .op_count(op_count), .err_count(err_count)
    );
`else
    alu_req_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );
`endif

    typedef struct {
        logic [2:0]  rv;
        logic [15:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // ALU model: add, sub, mul are legal; everything else reports no valid output.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.alu_out       <= '0;
            bus.alu_out_valid <= 1'b0;
        end else if (bus.alu_en) begin
            case (bus.alu_fun)
                4'h0: begin bus.alu_out <= {8'h00, bus.alu_a} + {8'h00, bus.alu_b}; bus.alu_out_valid <= 1'b1; end
                4'h1: begin bus.alu_out <= {8'h00, bus.alu_a - bus.alu_b};          bus.alu_out_valid <= 1'b1; end
                4'h2: begin bus.alu_out <= {8'h00, bus.alu_a} * {8'h00, bus.alu_b}; bus.alu_out_valid <= 1'b1; end
                default: begin bus.alu_out <= 16'hDEAD;                              bus.alu_out_valid <= 1'b0; end
            endcase
        end else begin
            bus.alu_out_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
            if (|bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.rv));
                    chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    chk("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                e = sb.pop_front();
                chk("rsp_late", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic do_req(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] f, input logic [15:0] d, input logic er);
        exp_t e;
        int   n;
        @(negedge CLK);
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
        bus.req_fun[i*4 +: 4] = f;
        bus.req_valid[i] = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[i] && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("accept", 32'(bus.req_ready[i]), 32'd1);
        e.rv   = 3'(1 << i);
        e.data = d;
        e.err  = er;
        e.due  = cyc + 3;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        bus.req_valid[i] = 1'b0;
        @(negedge CLK);
        chk("issue_alu_en", 32'(bus.alu_en), 32'd1);
        chk("issue_alu_a", 32'(bus.alu_a), 32'(a));
        chk("issue_alu_b", 32'(bus.alu_b), 32'(b));
        chk("issue_alu_fun", 32'(bus.alu_fun), 32'(f));
        @(negedge CLK);
        chk("wait_alu_en", 32'(bus.alu_en), 32'd0);
        chk("wait_alu_a", 32'(bus.alu_a), 32'(a));
        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(negedge CLK);
            #1;
            n++;
        end
    endtask

    initial begin
        exp_t e;
        int   c;
        int   n;
        RST = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_fun = '0;
        repeat (3) @(negedge CLK);
        bus.req_valid = 3'b111;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_alu_en", 32'(bus.alu_en), 32'd0);
        chk("rst_alu_abf", {bus.alu_a, bus.alu_b, 12'(bus.alu_fun)}, 32'd0);
        bus.req_valid = '0;
        @(negedge CLK);
        RST = 1'b1;

        do_req(1, 8'h05, 8'h03, 4'h0, 16'h0008, 1'b0);
        do_req(0, 8'hFF, 8'h02, 4'h2, 16'h01FE, 1'b0);
        do_req(2, 8'h12, 8'h34, 4'hF, 16'h0000, 1'b1);
        do_req(1, 8'hFF, 8'hFF, 4'h2, 16'hFE01, 1'b0);
        do_req(0, 8'h10, 8'h03, 4'h1, 16'h000D, 1'b0);
`ifdef ALU_ARB_STATS_EN
        chk("op_count_5", 32'(op_count), 32'd5);
        chk("err_count_1", 32'(err_count), 32'd1);
`endif

        // Round robin with all requesters held from reset.
        @(negedge CLK);
        RST = 1'b0;
        bus.req_a = {8'h00, 8'h03, 8'h01};
        bus.req_b = {8'h00, 8'h04, 8'h01};
        bus.req_fun = {4'hF, 4'h2, 4'h0};
        bus.req_valid = 3'b111;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rr_first_grant", 32'(bus.req_ready), 32'b001);
        c = cyc;
        e.rv = 3'b001; e.data = 16'h0002; e.err = 1'b0; e.due = c + 3;  sb.push_back(e);
        e.rv = 3'b010; e.data = 16'h000C; e.err = 1'b0; e.due = c + 6;  sb.push_back(e);
        e.rv = 3'b100; e.data = 16'h0000; e.err = 1'b1; e.due = c + 9;  sb.push_back(e);
        e.rv = 3'b001; e.data = 16'h0002; e.err = 1'b0; e.due = c + 12; sb.push_back(e);
        e.rv = 3'b010; e.data = 16'h000C; e.err = 1'b0; e.due = c + 15; sb.push_back(e);
        while (cyc < c + 14) @(negedge CLK);
        bus.req_valid = '0;
        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(negedge CLK);
            #1;
            n++;
        end
`ifdef ALU_ARB_STATS_EN
        chk("op_count_rr", 32'(op_count), 32'd5);
        chk("err_count_rr", 32'(err_count), 32'd1);
`endif

        // Reset during WAIT drops the in-flight op.
        @(negedge CLK);
        bus.req_a[16 +: 8] = 8'h07;
        bus.req_b[16 +: 8] = 8'h09;
        bus.req_fun[8 +: 4] = 4'h0;
        bus.req_valid[2] = 1'b1;
        #1;
        chk("midop_grant", 32'(bus.req_ready), 32'b100);
        @(posedge CLK);
        #1;
        bus.req_valid[2] = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("midop_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midop_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("midop_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("midop_alu_en", 32'(bus.alu_en), 32'd0);
        chk("midop_alu_abf", {bus.alu_a, bus.alu_b, 12'(bus.alu_fun)}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        do_req(0, 8'h10, 8'h03, 4'h1, 16'h000D, 1'b0);
`ifdef ALU_ARB_STATS_EN
        chk("op_count_after_rst", 32'(op_count), 32'd1);
        chk("err_count_after_rst", 32'(err_count), 32'd0);
`endif
        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=%0d required=<10000 cycles", cyc);
        $fatal(1, "timeout");
    end
endmodule
